// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, forwards operands and
// detects hazards. Define ID_EX_FWD_EN to build the forwarding muxes.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_asel,
    input  logic            id_bsel,
    input  logic            id_reg_wen,
    input  logic            id_mem_read,
    input  logic            flush,
    input  logic            ex_ready,
    input  logic [RAW-1:0]  exmem_rd,
    input  logic            exmem_wen,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RAW-1:0]  memwb_rd,
    input  logic            memwb_wen,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] dataA,
    output logic [XLEN-1:0] dataB,
    output logic [3:0]      sel_ALU,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RAW-1:0]  ex_rd,
    output logic            ex_reg_wen,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_pc
);

    logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
    logic [RAW-1:0]  rs1_q, rs2_q;
    logic            asel_q, bsel_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            hazard;

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB; x0 is never forwarded
    always_comb begin
        rs1_fwd = rs1_data_q;
        rs2_fwd = rs2_data_q;
        if (exmem_wen && exmem_rd == rs1_q && rs1_q != '0)
            rs1_fwd = exmem_result;
        else if (memwb_wen && memwb_rd == rs1_q && rs1_q != '0)
            rs1_fwd = memwb_result;
        if (exmem_wen && exmem_rd == rs2_q && rs2_q != '0)
            rs2_fwd = exmem_result;
        else if (memwb_wen && memwb_rd == rs2_q && rs2_q != '0)
            rs2_fwd = memwb_result;
    end

    assign hazard = ex_valid && ex_mem_read && ex_rd != '0 &&
                    (ex_rd == id_rs1 || ex_rd == id_rs2);
`else
    logic unused_results;
    logic rs1_busy, rs2_busy;

    assign unused_results = ^{exmem_result, memwb_result};
    assign rs1_fwd = rs1_data_q;
    assign rs2_fwd = rs2_data_q;

    // Without forwarding, any in-flight writer of a source register stalls decode
    assign rs1_busy = id_rs1 != '0 &&
                      ((ex_valid && ex_reg_wen && ex_rd == id_rs1) ||
                       (exmem_wen && exmem_rd == id_rs1) ||
                       (memwb_wen && memwb_rd == id_rs1));
    assign rs2_busy = id_rs2 != '0 &&
                      ((ex_valid && ex_reg_wen && ex_rd == id_rs2) ||
                       (exmem_wen && exmem_rd == id_rs2) ||
                       (memwb_wen && memwb_rd == id_rs2));
    assign hazard = rs1_busy || rs2_busy;
`endif

    assign id_ready      = (!ex_valid || ex_ready) && !hazard;
    assign dataA         = asel_q ? ex_pc : rs1_fwd;
    assign dataB         = bsel_q ? imm_q : rs2_fwd;
    assign ex_store_data = rs2_fwd;

    // Flush > capture > bubble > hold (hold refreshes operands from forwarding)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ex_rd       <= '0;
            sel_ALU     <= 4'b0000;
            asel_q      <= 1'b0;
            bsel_q      <= 1'b0;
            ex_reg_wen  <= 1'b0;
            ex_mem_read <= 1'b0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_reg_wen  <= 1'b0;
            ex_mem_read <= 1'b0;
        end else if (id_valid && id_ready) begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            rs1_data_q  <= id_rs1_data;
            rs2_data_q  <= id_rs2_data;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            ex_rd       <= id_rd;
            sel_ALU     <= id_alu_sel;
            asel_q      <= id_asel;
            bsel_q      <= id_bsel;
            ex_reg_wen  <= id_reg_wen;
            ex_mem_read <= id_mem_read;
        end else if (ex_valid && ex_ready) begin
            ex_valid    <= 1'b0;
            ex_reg_wen  <= 1'b0;
            ex_mem_read <= 1'b0;
        end else if (ex_valid) begin
            rs1_data_q  <= rs1_fwd;
            rs2_data_q  <= rs2_fwd;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table through a scoreboard queue,
// then hand-written forwarding, hazard, stall, flush and reset sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_sel;
    logic        id_asel, id_bsel, id_reg_wen, id_mem_read;
    logic        flush, ex_ready;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_wen, memwb_wen;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] dataA, dataB, ex_store_data, ex_pc;
    logic [3:0]  sel_ALU;
    logic [4:0]  ex_rd;
    logic        ex_reg_wen, ex_mem_read;

    int errors = 0;
    int checks = 0;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_sel(id_alu_sel), .id_asel(id_asel), .id_bsel(id_bsel),
        .id_reg_wen(id_reg_wen), .id_mem_read(id_mem_read), .flush(flush),
        .ex_ready(ex_ready), .exmem_rd(exmem_rd), .exmem_wen(exmem_wen),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_wen(memwb_wen),
        .memwb_result(memwb_result), .ex_valid(ex_valid), .dataA(dataA),
        .dataB(dataB), .sel_ALU(sel_ALU), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
        .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  sel;
        logic        asel, bsel, wen, mrd;
        logic [31:0] exp_a, exp_b, exp_st;
    } vec_t;

    typedef struct {
        logic [31:0] a, b, st, pc;
        logic [4:0]  rd;
        logic [3:0]  sel;
        logic        wen;
    } exp_t;

    vec_t vecs[4];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, rs1d, rs2d, imm, input logic [4:0] rs1, rs2, rd,
                         input logic [3:0] sel, input logic asel, bsel, wen, mrd);
        id_valid = 1'b1;
        id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_sel = sel;
        id_asel = asel; id_bsel = bsel; id_reg_wen = wen; id_mem_read = mrd;
    endtask

    task automatic idle_id();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        exmem_rd = '0; exmem_wen = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_wen = 1'b0; memwb_result = '0;

        vecs[0] = '{32'h10,  32'h5,    32'h7,    32'h0,        5'd1, 5'd2, 5'd8,  4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5,    32'h7,        32'h7};
        vecs[1] = '{32'h100, 32'h11,   32'h22,   32'hFFFFFFFC, 5'd3, 5'd4, 5'd9,  4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100,  32'hFFFFFFFC, 32'h22};
        vecs[2] = '{32'h200, 32'hAAAA, 32'hBBBB, 32'h40,       5'd5, 5'd6, 5'd10, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200,  32'hBBBB,     32'hBBBB};
        vecs[3] = '{32'h300, 32'hCAFE, 32'h99,   32'h7FF,      5'd7, 5'd0, 5'd0,  4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE, 32'h7FF,      32'h99};

        #12;
        chk("reset ex_valid", 32'(ex_valid), 0);
        chk("reset dataA", dataA, 0);
        chk("reset dataB", dataB, 0);
        chk("reset sel_ALU", 32'(sel_ALU), 0);
        chk("reset ex_reg_wen", 32'(ex_reg_wen), 0);
        chk("reset ex_mem_read", 32'(ex_mem_read), 0);
        chk("reset id_ready", 32'(id_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table: one instruction per cycle, expected pushed at drive, popped after edge
        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].rs1d, vecs[i].rs2d, vecs[i].imm, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].rd, vecs[i].sel, vecs[i].asel, vecs[i].bsel, vecs[i].wen, vecs[i].mrd);
            #1;
            chk($sformatf("vec%0d id_ready", i), 32'(id_ready), 1);
            sb.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_st, vecs[i].pc,
                           vecs[i].rd, vecs[i].sel, vecs[i].wen});
            step();
            e = sb.pop_front();
            chk($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 1);
            chk($sformatf("vec%0d dataA", i), dataA, e.a);
            chk($sformatf("vec%0d dataB", i), dataB, e.b);
            chk($sformatf("vec%0d store", i), ex_store_data, e.st);
            chk($sformatf("vec%0d sel_ALU", i), 32'(sel_ALU), 32'(e.sel));
            chk($sformatf("vec%0d ex_rd", i), 32'(ex_rd), 32'(e.rd));
            chk($sformatf("vec%0d ex_pc", i), ex_pc, e.pc);
            chk($sformatf("vec%0d reg_wen", i), 32'(ex_reg_wen), 32'(e.wen));
        end

        // Forwarding priority: held rs1=x3 with both sources matching
        drive(32'h400, 32'h0, 32'h77, 32'h0, 5'd3, 5'd0, 5'd12, 4'h1, 0, 0, 1, 0);
        step();
        idle_id(); ex_ready = 1'b0;
        exmem_rd = 5'd3; exmem_wen = 1'b1; exmem_result = 32'h1234;
        memwb_rd = 5'd3; memwb_wen = 1'b1; memwb_result = 32'hDEAD;
        #1;
        chk("fwd exmem dataA", dataA, FWD ? 32'h1234 : 32'h0);
        chk("fwd x0 rs2 dataB", dataB, 32'h77);
        exmem_wen = 1'b0;
        #1;
        chk("fwd memwb dataA", dataA, FWD ? 32'hDEAD : 32'h0);
        memwb_wen = 1'b0;
        #1;
        chk("fwd none dataA", dataA, 32'h0);

        // x0 is never forwarded
        exmem_rd = 5'd0; exmem_wen = 1'b1; memwb_rd = 5'd0; memwb_wen = 1'b1;
        ex_ready = 1'b1;
        drive(32'h500, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd13, 4'h1, 0, 0, 1, 0);
        step();
        chk("x0 ex_valid", 32'(ex_valid), 1);
        chk("x0 dataA", dataA, 32'h0);
        exmem_wen = 1'b0; memwb_wen = 1'b0;

        // EX/MEM writer stalls decode only when forwarding is absent
        idle_id(); id_rs1 = 5'd3;
        exmem_rd = 5'd3; exmem_wen = 1'b1;
        #1;
        chk("exmem hazard id_ready", 32'(id_ready), FWD ? 32'h1 : 32'h0);
        exmem_wen = 1'b0; id_rs1 = '0;

        // Load-use: one bubble, then accept
        drive(32'h600, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd4, 4'h0, 0, 0, 1, 1);
        step();
        chk("load held mem_read", 32'(ex_mem_read), 1);
        drive(32'h604, 32'h3, 32'h4, 32'h0, 5'd1, 5'd4, 5'd11, 4'h1, 0, 0, 1, 0);
        #1;
        chk("loaduse id_ready", 32'(id_ready), 0);
        step();
        chk("bubble ex_valid", 32'(ex_valid), 0);
        chk("bubble reg_wen", 32'(ex_reg_wen), 0);
        chk("bubble mem_read", 32'(ex_mem_read), 0);
        chk("after bubble id_ready", 32'(id_ready), 1);
        step();
        chk("loaduse accept ex_valid", 32'(ex_valid), 1);
        chk("loaduse accept ex_rd", 32'(ex_rd), 11);

        // Stall refresh: MEM/WB value seen once must persist while held
        drive(32'h700, 32'h10, 32'h0, 32'h0, 5'd6, 5'd0, 5'd14, 4'h1, 0, 0, 1, 0);
        step();
        idle_id(); ex_ready = 1'b0;
        memwb_rd = 5'd6; memwb_wen = 1'b1; memwb_result = 32'h55;
        #1;
        chk("stall c1 dataA", dataA, FWD ? 32'h55 : 32'h10);
        step();
        memwb_wen = 1'b0; memwb_result = 32'h0;
        #1;
        chk("stall c2 dataA", dataA, FWD ? 32'h55 : 32'h10);
        step();
        chk("stall c3 dataA", dataA, FWD ? 32'h55 : 32'h10);
        chk("stall c3 ex_valid", 32'(ex_valid), 1);

        // Flush wins over a same-edge capture
        ex_ready = 1'b1; flush = 1'b1;
        drive(32'h800, 32'h1, 32'h1, 32'h0, 5'd1, 5'd1, 5'd15, 4'h3, 0, 0, 1, 1);
        step();
        flush = 1'b0;
        chk("flush ex_valid", 32'(ex_valid), 0);
        chk("flush reg_wen", 32'(ex_reg_wen), 0);
        chk("flush mem_read", 32'(ex_mem_read), 0);
        step();
        chk("represent ex_rd", 32'(ex_rd), 15);

        // Hold blocks decode; async reset clears the held instruction mid-cycle
        ex_ready = 1'b0;
        drive(32'h900, 32'h2, 32'h2, 32'h0, 5'd2, 5'd2, 5'd16, 4'h4, 0, 0, 1, 0);
        #1;
        chk("hold id_ready", 32'(id_ready), 0);
        step();
        chk("hold ex_rd", 32'(ex_rd), 15);
        id_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst ex_valid", 32'(ex_valid), 0);
        chk("async rst ex_rd", 32'(ex_rd), 0);
        #1;
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
